line_rasterizer: RTL and testbench

LINE_RASTERIZER -- requirements
Module: line_rasterizer

---
 rtl/line_rasterizer_pkg.sv | 26 ++
 rtl/line_rasterizer.sv | 150 +++++++++++++++
 tb/tb_line_rasterizer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/line_rasterizer_pkg.sv
// Shared widths, display defaults and FSM encoding for the line rasterizer
// and any pixel stage that consumes its output.
package line_rasterizer_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int C_W       = 8;
  localparam int ERR_W     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]   x0;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y0;
    logic [Y_W-1:0]   y1;
    logic [3*C_W-1:0] color;
  } cmd_t;

endpackage

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: one command in, one pixel per step out with
// valid/ready backpressure; off-screen points are skipped one per cycle.
module line_rasterizer
  import line_rasterizer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic           pixclk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [23:0]    color,
  output logic [X_W-1:0] xCoord,
  output logic [Y_W-1:0] yCoord,
  output logic [C_W-1:0] red_vect,
  output logic [C_W-1:0] green_vect,
  output logic [C_W-1:0] blue_vect,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           busy,
  output logic           done
);

  state_t                  state;
  cmd_t                    cmd;
  logic [X_W-1:0]          cur_x;
  logic [Y_W-1:0]          cur_y;
  logic signed [ERR_W-1:0] dx, dy, err;
  logic                    sx_neg, sy_neg;

  logic [X_W-1:0]          adx;
  logic [Y_W-1:0]          ady;
  logic signed [ERR_W:0]   e2, dx_w, dy_w;
  logic                    step_x, step_y;
  logic signed [ERR_W-1:0] err_nxt;
  logic [X_W-1:0]          pt_x;
  logic [Y_W-1:0]          pt_y;
  logic                    pt_in, step_done, at_end;

  always_comb begin
    adx     = (cmd.x1 >= cmd.x0) ? cmd.x1 - cmd.x0 : cmd.x0 - cmd.x1;
    ady     = (cmd.y1 >= cmd.y0) ? cmd.y1 - cmd.y0 : cmd.y0 - cmd.y1;
    e2      = {err, 1'b0};
    dx_w    = {dx[ERR_W-1], dx};
    dy_w    = {dy[ERR_W-1], dy};
    step_x  = (e2 >= dy_w);
    step_y  = (e2 <= dx_w);
    // Both axis decisions come from the same pre-step error term.
    err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    if (state == SETUP) begin
      pt_x = cmd.x0;
      pt_y = cmd.y0;
    end else begin
      pt_x = cur_x;
      pt_y = cur_y;
      if (step_x) pt_x = sx_neg ? cur_x - X_W'(1) : cur_x + X_W'(1);
      if (step_y) pt_y = sy_neg ? cur_y - Y_W'(1) : cur_y + Y_W'(1);
    end
    pt_in     = (32'(pt_x) < 32'(H_RES)) && (32'(pt_y) < 32'(V_RES));
    // pix_valid already encodes in-bounds for the current point, so a
    // clipped point completes without waiting on downstream.
    step_done = (state == DRAW) && (!pix_valid || pix_ready);
    at_end    = (cur_x == cmd.x1) && (cur_y == cmd.y1);
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd        <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_valid  <= 1'b0;
      xCoord     <= '0;
      yCoord     <= '0;
      red_vect   <= '0;
      green_vect <= '0;
      blue_vect  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd       <= '{x0: x0, x1: x1, y0: y0, y1: y1, color: color};
            state     <= SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          dx     <= {2'b0, adx};
          dy     <= '0 - {3'b0, ady};
          err    <= {2'b0, adx} - {3'b0, ady};
          sx_neg <= !(cmd.x0 < cmd.x1);
          sy_neg <= !(cmd.y0 < cmd.y1);
          cur_x  <= pt_x;
          cur_y  <= pt_y;
          pix_valid <= pt_in;
          xCoord    <= pt_in ? pt_x : '0;
          yCoord    <= pt_in ? pt_y : '0;
          {red_vect, green_vect, blue_vect} <= pt_in ? cmd.color : '0;
          state  <= DRAW;
        end
        DRAW: begin
          if (step_done) begin
            if (at_end) begin
              state      <= IDLE;
              done       <= 1'b1;
              busy       <= 1'b0;
              cmd_ready  <= 1'b1;
              pix_valid  <= 1'b0;
              xCoord     <= '0;
              yCoord     <= '0;
              red_vect   <= '0;
              green_vect <= '0;
              blue_vect  <= '0;
            end else begin
              cur_x     <= pt_x;
              cur_y     <= pt_y;
              err       <= err_nxt;
              pix_valid <= pt_in;
              xCoord    <= pt_in ? pt_x : '0;
              yCoord    <= pt_in ? pt_y : '0;
              {red_vect, green_vect, blue_vect} <= pt_in ? cmd.color : '0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed and randomized lines against an integer Bresenham point-list model,
// with random backpressure, clipping and mid-line reset.
module tb_line_rasterizer;
  import line_rasterizer_pkg::*;

  logic        pixclk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, pix_valid, pix_ready, busy, done;
  logic [9:0]  x0, x1, xCoord;
  logic [8:0]  y0, y1, yCoord;
  logic [23:0] color;
  logic [7:0]  red_vect, green_vect, blue_vect;

  int checks = 0;
  int errors = 0;
  int ex_q[$];
  int ey_q[$];
  int n_steps;
  bit first_in;

  line_rasterizer #(.H_RES(640), .V_RES(480)) dut (
    .pixclk(pixclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .xCoord(xCoord), .yCoord(yCoord), .red_vect(red_vect), .green_vect(green_vect),
    .blue_vect(blue_vect), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  always #5 pixclk = ~pixclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Expected on-screen points of a line, in drawing order.
  function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
    int x, y, dx, dy, sx, sy, err, e2;
    ex_q.delete();
    ey_q.delete();
    n_steps = 0;
    x = ax0; y = ay0;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    first_in = (ax0 < 640) && (ay0 < 480);
    while (1) begin
      if (x < 640 && y < 480) begin
        ex_q.push_back(x);
        ey_q.push_back(y);
      end
      n_steps++;
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                       input logic [23:0] col, input string tag);
    int c;
    c = 0;
    while (!cmd_ready && c < 100) begin tick(); c++; end
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1); color = col;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    // Scramble inputs: a latched command must not follow them.
    x0 = 10'($urandom); y0 = 9'($urandom); x1 = 10'($urandom); y1 = 9'($urandom);
    color = 24'($urandom);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall second pixel 3 cycles
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic [23:0] col, input int mode, input string tag,
                          output int acc);
    int c, stalls, held, hold_pix;
    bit fin, prev_stall, r;
    logic [9:0] hx;
    logic [8:0] hy;
    logic [23:0] hc;
    model(ax0, ay0, ax1, ay1);
    issue(ax0, ay0, ax1, ay1, col, tag);
    chk({tag, "_setup"}, {busy, cmd_ready, pix_valid}, 3'b100);
    c = 1; stalls = 0; held = 0; hold_pix = 0; acc = 0; fin = 0; prev_stall = 0;
    hx = '0; hy = '0; hc = '0;
    while (!fin && c < 5000) begin
      if (done) begin
        fin = 1;
      end else begin
        if (c == 2) chk({tag, "_first_valid"}, pix_valid, first_in);
        if (prev_stall)
          chk({tag, "_hold"}, {pix_valid, xCoord, yCoord, red_vect, green_vect, blue_vect},
              {1'b1, hx, hy, hc});
        if (!pix_valid)
          chk({tag, "_zero"}, {xCoord, yCoord, red_vect, green_vect, blue_vect}, 0);
        case (mode)
          0:       r = 1;
          1:       r = ($urandom_range(0, 3) != 0);
          default: r = !(acc == 1 && held < 3);
        endcase
        pix_ready = r;
        if (pix_valid && acc == 1) hold_pix++;
        if (pix_valid) begin
          if (r) begin
            if (ex_q.size() == 0) begin
              chk({tag, "_extra_pixel"}, {xCoord, yCoord}, 0);
            end else begin
              chk({tag, "_pix"}, {xCoord, yCoord, red_vect, green_vect, blue_vect},
                  {10'(ex_q.pop_front()), 9'(ey_q.pop_front()), col});
            end
            acc++;
          end else begin
            stalls++;
            held++;
          end
        end
        prev_stall = pix_valid && !r;
        hx = xCoord; hy = yCoord; hc = {red_vect, green_vect, blue_vect};
        tick();
        c++;
      end
    end
    chk({tag, "_finished"}, fin, 1);
    if (fin) begin
      chk({tag, "_done_cycle"}, c, 2 + n_steps + stalls);
      chk({tag, "_idle_flags"}, {cmd_ready, busy, pix_valid}, 3'b100);
      chk({tag, "_missing"}, ex_q.size(), 0);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
    end
    if (mode == 2) chk({tag, "_held_cycles"}, hold_pix, 4);
    pix_ready = 1'b1;
  endtask

  initial begin
    int acc, ax0, ay0, ax1, ay1;
    reset = 1'b1; cmd_valid = 1'b0; pix_ready = 1'b1;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    #1;
    chk("reset_outs", {pix_valid, busy, done, xCoord, yCoord, red_vect, green_vect, blue_vect}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_cmd_ready", cmd_ready, 1);

    run_line(0, 0, 3, 0, 24'hA1B2C3, 0, "horiz", acc);
    chk("horiz_count", acc, 4);
    run_line(5, 9, 3, 3, 24'h123456, 0, "steep", acc);
    chk("steep_count", acc, 7);
    run_line(10, 10, 12, 12, 24'hFF00FF, 2, "bp", acc);
    chk("bp_count", acc, 3);
    run_line(636, 5, 643, 5, 24'h00FF00, 0, "clip", acc);
    chk("clip_count", acc, 4);
    run_line(7, 7, 7, 7, 24'h0F0F0F, 0, "point", acc);
    chk("point_count", acc, 1);

    // Abort a long line mid-draw.
    issue(0, 0, 100, 0, 24'h777777, "rst");
    for (int i = 0; i < 12; i++) tick();
    chk("rst_drawing", {busy, pix_valid}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {pix_valid, busy, done, xCoord, yCoord}, 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_done", {done, busy, pix_valid}, 0);
      tick();
    end
    run_line(2, 3, 9, 1, 24'hABCDEF, 0, "after_rst", acc);
    chk("after_rst_count", acc, 8);

    for (int n = 0; n < 40; n++) begin
      ax0 = $urandom_range(0, 1023);
      ay0 = $urandom_range(0, 511);
      if (n < 6) begin
        ax1 = $urandom_range(0, 1023);
        ay1 = $urandom_range(0, 511);
      end else begin
        ax1 = ax0 + $urandom_range(0, 60) - 30;
        ay1 = ay0 + $urandom_range(0, 60) - 30;
        ax1 = (ax1 < 0) ? 0 : (ax1 > 1023) ? 1023 : ax1;
        ay1 = (ay1 < 0) ? 0 : (ay1 > 511) ? 511 : ay1;
      end
      run_line(ax0, ay0, ax1, ay1, 24'($urandom), 1, "rand", acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
